// File: rtl/top_pkg.sv
// Shared types for the instruction-fetch/decode slice: widths, RV32I opcodes,
// ALU/branch op encodings and decoded-instruction payload structs.
package top_pkg;

   localparam int unsigned cXLEN       = 32;
   localparam int unsigned cIMEM_DEPTH = 2048;
   localparam int unsigned cIDX_W      = 11;
   localparam int unsigned cPTR_W      = 12;

   localparam logic [6:0] cOP_LOAD   = 7'h03;
   localparam logic [6:0] cOP_IMM    = 7'h13;
   localparam logic [6:0] cOP_AUIPC  = 7'h17;
   localparam logic [6:0] cOP_STORE  = 7'h23;
   localparam logic [6:0] cOP_OP     = 7'h33;
   localparam logic [6:0] cOP_LUI    = 7'h37;
   localparam logic [6:0] cOP_BRANCH = 7'h63;
   localparam logic [6:0] cOP_JALR   = 7'h67;
   localparam logic [6:0] cOP_JAL    = 7'h6F;

   typedef enum logic [3:0] {
      ARIT_ADD  = 4'd0, ARIT_SUB = 4'd1, ARIT_SLL = 4'd2, ARIT_SLT = 4'd3,
      ARIT_SLTU = 4'd4, ARIT_XOR = 4'd5, ARIT_SRL = 4'd6, ARIT_SRA = 4'd7,
      ARIT_OR   = 4'd8, ARIT_AND = 4'd9
   } arit_e;

   typedef enum logic [2:0] {
      BR_BEQ = 3'd0, BR_BNE = 3'd1, BR_BLT = 3'd2, BR_BGE  = 3'd3,
      BR_BLTU = 3'd4, BR_BGEU = 3'd5, BR_JAL = 3'd6, BR_JALR = 3'd7
   } br_e;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_HALT} state_e;

   typedef struct packed {
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [2:0]       f3;
      logic [6:0]       f7;
      logic [6:0]       opcode;
      logic [cXLEN-1:0] imm;
   } fields_t;

   typedef struct packed {
      logic load;
      logic store;
      logic dv;
   } mem_op_t;

   typedef struct packed {
      arit_e arit;
      logic  op_rs1;
      logic  op_rs2;
      logic  op_imm;
      logic  op_pc;
      logic  op_const;
      logic  dv;
   } reg_op_t;

   typedef struct packed {
      br_e  op;
      logic dv;
   } br_op_t;

   typedef struct packed {
      fields_t fields;
      mem_op_t mem;
      reg_op_t regop;
      br_op_t  br;
      logic    illegal;
   } dec_t;

   // alt selects SUB/SRA from funct7[5]; SUB only exists for register-register ops
   function automatic arit_e arit_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
      arit_e a;
      case (f3)
         3'd0:    a = (alt && is_reg) ? ARIT_SUB : ARIT_ADD;
         3'd1:    a = ARIT_SLL;
         3'd2:    a = ARIT_SLT;
         3'd3:    a = ARIT_SLTU;
         3'd4:    a = ARIT_XOR;
         3'd5:    a = alt ? ARIT_SRA : ARIT_SRL;
         3'd6:    a = ARIT_OR;
         default: a = ARIT_AND;
      endcase
      return a;
   endfunction

   function automatic br_e br_sel(input logic [2:0] f3);
      br_e b;
      case (f3)
         3'd1:    b = BR_BNE;
         3'd4:    b = BR_BLT;
         3'd5:    b = BR_BGE;
         3'd6:    b = BR_BLTU;
         3'd7:    b = BR_BGEU;
         default: b = BR_BEQ;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/top_inst_decoder.sv
// Combinational RV32I decoder: instruction word to field, memory, register-op
// and branch payloads; flags unknown opcodes as illegal.
module inst_decoder
   import top_pkg::*;
(
   input  logic [cXLEN-1:0] inst_i,
   output dec_t             dec_o
);

   logic [cXLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'b0};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      dec_o = '0;
      dec_o.fields.rs1    = inst_i[19:15];
      dec_o.fields.rs2    = inst_i[24:20];
      dec_o.fields.rd     = inst_i[11:7];
      dec_o.fields.f3     = inst_i[14:12];
      dec_o.fields.f7     = inst_i[31:25];
      dec_o.fields.opcode = inst_i[6:0];
      case (inst_i[6:0])
         cOP_OP: begin
            dec_o.regop.arit   = arit_sel(inst_i[14:12], inst_i[30], 1'b1);
            dec_o.regop.op_rs1 = 1'b1;
            dec_o.regop.op_rs2 = 1'b1;
            dec_o.regop.dv     = 1'b1;
         end
         cOP_IMM: begin
            dec_o.fields.imm   = imm_i;
            dec_o.regop.arit   = arit_sel(inst_i[14:12], inst_i[30], 1'b0);
            dec_o.regop.op_rs1 = 1'b1;
            dec_o.regop.op_imm = 1'b1;
            dec_o.regop.dv     = 1'b1;
         end
         cOP_LUI: begin
            dec_o.fields.imm   = imm_u;
            dec_o.regop.op_imm = 1'b1;
            dec_o.regop.dv     = 1'b1;
         end
         cOP_AUIPC: begin
            dec_o.fields.imm   = imm_u;
            dec_o.regop.op_pc  = 1'b1;
            dec_o.regop.op_imm = 1'b1;
            dec_o.regop.dv     = 1'b1;
         end
         cOP_JAL, cOP_JALR: begin
            // link value PC+4 is produced by the ALU as PC + constant
            dec_o.fields.imm     = (inst_i[6:0] == cOP_JAL) ? imm_j : imm_i;
            dec_o.regop.op_pc    = 1'b1;
            dec_o.regop.op_const = 1'b1;
            dec_o.regop.dv       = 1'b1;
            dec_o.br.op          = (inst_i[6:0] == cOP_JAL) ? BR_JAL : BR_JALR;
            dec_o.br.dv          = 1'b1;
         end
         cOP_LOAD: begin
            dec_o.fields.imm = imm_i;
            dec_o.mem.load   = 1'b1;
            dec_o.mem.dv     = 1'b1;
         end
         cOP_STORE: begin
            dec_o.fields.imm = imm_s;
            dec_o.mem.store  = 1'b1;
            dec_o.mem.dv     = 1'b1;
         end
         cOP_BRANCH: begin
            dec_o.fields.imm = imm_b;
            dec_o.br.op      = br_sel(inst_i[14:12]);
            dec_o.br.dv      = 1'b1;
         end
         default: dec_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/top.sv
// Instruction memory, sequential fetch FSM and registered decode stage.
// Build option ILLEGAL_HALT_EN: an unknown opcode during RUN halts the FSM.
module top
   import top_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             iStart,
   input  logic [cXLEN-1:0] iInst2Write,
   input  logic             iInstWen,
   output logic [4:0]       oRs1Addr,
   output logic [4:0]       oRs2Addr,
   output logic [4:0]       oRdAddr,
   output logic [2:0]       oF3,
   output logic [6:0]       oF7,
   output logic [6:0]       oOpcode,
   output logic [cXLEN-1:0] oImm,
   output logic [cXLEN-1:0] oCurPc,
   output logic             oLoad,
   output logic             oStore,
   output logic             oMemDv,
   output logic [3:0]       oAritType,
   output logic             oOpRs1,
   output logic             oOpRs2,
   output logic             oOpImm,
   output logic             oOpPc,
   output logic             oOpConst,
   output logic             oOpDv,
   output logic [2:0]       oBrOp,
   output logic             oBrDv
);

   logic [cXLEN-1:0]  mem [cIMEM_DEPTH];
   state_e            state_q, state_d;
   logic [cXLEN-1:0]  pc_q, pc_d;
   logic [cPTR_W-1:0] ptr_q, ptr_d;
   logic              wr_c, issue_c, halt_c;
   logic              s1_valid_q;
   logic [cXLEN-1:0]  s1_pc_q, word_q;
   dec_t              dec;
   fields_t           fields_q;
   mem_op_t           mem_q;
   reg_op_t           reg_q;
   br_op_t            br_q;

   inst_decoder u_dec (.inst_i(word_q), .dec_o(dec));

`ifdef ILLEGAL_HALT_EN
   assign halt_c = s1_valid_q && dec.illegal && (state_q == ST_RUN);
`else
   logic unused_illegal;
   assign unused_illegal = dec.illegal;
   assign halt_c = 1'b0;
`endif

   // Next-state: loading in IDLE, one fetch per cycle in RUN until PC hits the loaded end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      wr_c    = 1'b0;
      issue_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iInstWen && !ptr_q[cPTR_W-1]) begin
               wr_c  = 1'b1;
               ptr_d = ptr_q + cPTR_W'(1);
            end
            if (iStart) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN: begin
            if (halt_c) begin
               state_d = ST_HALT;
            end else if (pc_q == cXLEN'({ptr_q, 2'b00})) begin
               state_d = ST_DONE;
            end else begin
               issue_c = 1'b1;
               pc_d    = pc_q + cXLEN'(4);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_c) mem[ptr_q[cIDX_W-1:0]] <= iInst2Write;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_pc_q    <= '0;
         word_q     <= '0;
         fields_q   <= '0;
         mem_q      <= '0;
         reg_q      <= '0;
         br_q       <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ptr_q      <= ptr_d;
         s1_valid_q <= issue_c;
         if (issue_c) begin
            word_q  <= mem[pc_q[cIDX_W+1:2]];
            s1_pc_q <= pc_q;
         end
         // fields always track the fetched word; op flags only for live fetches
         fields_q <= dec.fields;
         mem_q    <= s1_valid_q ? dec.mem   : '0;
         reg_q    <= s1_valid_q ? dec.regop : '0;
         br_q     <= s1_valid_q ? dec.br    : '0;
      end
   end

   logic [cXLEN-1:0] cur_pc_q;
   always_ff @(posedge clk) begin
      if (rst) cur_pc_q <= '0;
      else     cur_pc_q <= s1_pc_q;
   end

   assign oRs1Addr  = fields_q.rs1;
   assign oRs2Addr  = fields_q.rs2;
   assign oRdAddr   = fields_q.rd;
   assign oF3       = fields_q.f3;
   assign oF7       = fields_q.f7;
   assign oOpcode   = fields_q.opcode;
   assign oImm      = fields_q.imm;
   assign oCurPc    = cur_pc_q;
   assign oLoad     = mem_q.load;
   assign oStore    = mem_q.store;
   assign oMemDv    = mem_q.dv;
   assign oAritType = reg_q.arit;
   assign oOpRs1    = reg_q.op_rs1;
   assign oOpRs2    = reg_q.op_rs2;
   assign oOpImm    = reg_q.op_imm;
   assign oOpPc     = reg_q.op_pc;
   assign oOpConst  = reg_q.op_const;
   assign oOpDv     = reg_q.dv;
   assign oBrOp     = br_q.op;
   assign oBrDv     = br_q.dv;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: stimulus pushes expected decodes from a behavioural
// RV32I model; a negedge monitor pops and compares whenever any dv is high.
module tb_top;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iStart = 1'b0;
   logic        iInstWen = 1'b0;
   logic [31:0] iInst2Write = '0;
   logic [4:0]  oRs1Addr, oRs2Addr, oRdAddr;
   logic [2:0]  oF3, oBrOp;
   logic [6:0]  oF7, oOpcode;
   logic [31:0] oImm, oCurPc;
   logic        oLoad, oStore, oMemDv, oOpRs1, oOpRs2, oOpImm, oOpPc, oOpConst, oOpDv, oBrDv;
   logic [3:0]  oAritType;

   top dut (
      .clk(clk), .rst(rst), .iStart(iStart), .iInst2Write(iInst2Write), .iInstWen(iInstWen),
      .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr), .oRdAddr(oRdAddr), .oF3(oF3), .oF7(oF7),
      .oOpcode(oOpcode), .oImm(oImm), .oCurPc(oCurPc), .oLoad(oLoad), .oStore(oStore),
      .oMemDv(oMemDv), .oAritType(oAritType), .oOpRs1(oOpRs1), .oOpRs2(oOpRs2),
      .oOpImm(oOpImm), .oOpPc(oOpPc), .oOpConst(oOpConst), .oOpDv(oOpDv),
      .oBrOp(oBrOp), .oBrDv(oBrDv)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  f7, opc;
      logic [31:0] imm, pc;
      logic        load, store, memdv;
      logic [3:0]  arit;
      logic        ors1, ors2, oimm, opcsel, oconst, opdv;
      logic [2:0]  brop;
      logic        brdv;
   } exp_t;

   exp_t        act;
   exp_t        q[$];
   logic [31:0] prog[$];
   int          checks = 0;
   int          errors = 0;

   assign act = {oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oOpcode, oImm, oCurPc,
                 oLoad, oStore, oMemDv, oAritType, oOpRs1, oOpRs2, oOpImm, oOpPc,
                 oOpConst, oOpDv, oBrOp, oBrDv};

   // Reference decode computed from the instruction-set rules with plain arithmetic
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, output bit ok);
      exp_t e;
      int   sw, f3, alt, imm;
      int   alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      int   br_tab  [8] = '{0, 1, 0, 0, 2, 3, 4, 5};
      e      = '0;
      ok     = 1'b1;
      sw     = int'(w);
      f3     = int'((w >> 12) & 7);
      alt    = int'((w >> 30) & 1);
      e.rs1  = 5'((w >> 15) & 31);
      e.rs2  = 5'((w >> 20) & 31);
      e.rd   = 5'((w >> 7) & 31);
      e.f3   = 3'(f3);
      e.f7   = 7'(w >> 25);
      e.opc  = 7'(w & 127);
      e.pc   = pc;
      imm    = 0;
      case (int'(w & 127))
         'h33: begin
            e.ors1 = 1; e.ors2 = 1; e.opdv = 1;
            e.arit = 4'(alu_tab[f3] + (((f3 == 0) || (f3 == 5)) ? alt : 0));
         end
         'h13: begin
            e.ors1 = 1; e.oimm = 1; e.opdv = 1; imm = sw >>> 20;
            e.arit = 4'(alu_tab[f3] + ((f3 == 5) ? alt : 0));
         end
         'h37: begin e.oimm = 1; e.opdv = 1; imm = int'(w & 32'hFFFFF000); end
         'h17: begin e.opcsel = 1; e.oimm = 1; e.opdv = 1; imm = int'(w & 32'hFFFFF000); end
         'h6F: begin
            e.opcsel = 1; e.oconst = 1; e.opdv = 1; e.brop = 6; e.brdv = 1;
            imm = (w[31] ? -1048576 : 0) + int'((w >> 12) & 255) * 4096
                + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 1023) * 2;
         end
         'h67: begin
            e.opcsel = 1; e.oconst = 1; e.opdv = 1; e.brop = 7; e.brdv = 1; imm = sw >>> 20;
         end
         'h03: begin e.load = 1; e.memdv = 1; imm = sw >>> 20; end
         'h23: begin
            e.store = 1; e.memdv = 1;
            imm = (sw >>> 25) * 32 + int'((w >> 7) & 31);
         end
         'h63: begin
            e.brdv = 1; e.brop = 3'(br_tab[f3]);
            imm = (w[31] ? -4096 : 0) + int'((w >> 7) & 1) * 2048
                + int'((w >> 25) & 63) * 32 + int'((w >> 8) & 15) * 2;
         end
         default: ok = 1'b0;
      endcase
      e.imm = 32'(imm);
      return e;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      logic [6:0]  op;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h37;  3: op = 7'h17;
         4: op = 7'h6F;  5: op = 7'h67;  6: op = 7'h03;  7: op = 7'h23;
         8: op = 7'h63;  9: op = 7'h13;  default: op = 7'h7F;
      endcase
      w[6:0] = op;
      if (op == 7'h63 && w[14:13] == 2'b01) w[14] = 1'b1;
      return w;
   endfunction

   function automatic exp_t mk(input logic [31:0] w, input logic [31:0] imm, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [6:0] f7);
      exp_t e;
      e = '0;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.f7 = f7;
      e.opc = w[6:0]; e.imm = imm; e.pc = pc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && (oOpDv || oMemDv || oBrDv)) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dv act=%h", act);
         end else begin
            e = q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL decode pc=%h act=%h exp=%h", e.pc, act, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (act !== '0) begin
         errors++;
         $display("FAIL %s act=%h exp=0", name, act);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check_zero("reset_outputs");
      q.delete();
      rst = 1'b0;
   endtask

   task automatic load_prog();
      foreach (prog[i]) begin
         iInstWen    = 1'b1;
         iInst2Write = prog[i];
         tick();
      end
      iInstWen = 1'b0;
   endtask

   task automatic start();
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
   endtask

   task automatic push_model();
      exp_t e;
      bit   ok;
      bit   stop;
      stop = 1'b0;
      for (int i = 0; i < prog.size() && i < 2048 && !stop; i++) begin
         e = model(prog[i], 32'(i * 4), ok);
         if (ok) q.push_back(e);
`ifdef ILLEGAL_HALT_EN
         else stop = 1'b1;
`endif
      end
   endtask

   task automatic drain(input int n, input string name);
      repeat (n + 8) tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s pending=%0d exp=0", name, q.size());
         q.delete();
      end
   endtask

   task automatic rand_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rand_word());
   endtask

   initial begin
      exp_t e;
      do_reset();

      // addi x1,x2,5 with explicit latency check
      prog = '{32'h00510093};
      load_prog();
      e = mk(32'h00510093, 32'd5, 32'd0, 5'd2, 5'd5, 5'd1, 3'd0, 7'd0);
      e.ors1 = 1; e.oimm = 1; e.opdv = 1;
      q.push_back(e);
      start();
      tick();
      tick();
      checks++;
      if (oOpDv !== 1'b1 || oCurPc !== 32'd0) begin
         errors++;
         $display("FAIL latency act_dv=%b act_pc=%h exp_dv=1 exp_pc=0", oOpDv, oCurPc);
      end
      drain(1, "addi_drain");

      // sw x5,8(x6) then beq x0,x0,-4
      do_reset();
      prog = '{32'h00532423, 32'hFE000EE3};
      load_prog();
      e = mk(32'h00532423, 32'd8, 32'd0, 5'd6, 5'd5, 5'd8, 3'd2, 7'd0);
      e.store = 1; e.memdv = 1;
      q.push_back(e);
      e = mk(32'hFE000EE3, 32'hFFFFFFFC, 32'd4, 5'd0, 5'd0, 5'd29, 3'd0, 7'h7F);
      e.brop = 0; e.brdv = 1;
      q.push_back(e);
      start();
      drain(2, "store_branch_drain");

      // empty program goes straight to DONE
      do_reset();
      start();
      drain(0, "empty_drain");

      // reset mid-run, then reload and rerun from PC 0
      do_reset();
      rand_prog(12);
      load_prog();
      push_model();
      start();
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check_zero("mid_run_reset");
      q.delete();
      rst = 1'b0;
      load_prog();
      push_model();
      start();
      drain(12, "rerun_drain");

      // illegal word followed by addi
      do_reset();
      prog = '{32'hFFFFFFFF, 32'h00510093};
      load_prog();
`ifndef ILLEGAL_HALT_EN
      e = mk(32'h00510093, 32'd5, 32'd4, 5'd2, 5'd5, 5'd1, 3'd0, 7'd0);
      e.ors1 = 1; e.oimm = 1; e.opdv = 1;
      q.push_back(e);
`endif
      start();
      drain(2, "illegal_drain");

      // randomized programs against the model
      for (int t = 0; t < 8; t++) begin
         do_reset();
         rand_prog(int'($urandom_range(1, 24)));
         load_prog();
         push_model();
         start();
         drain(prog.size(), "random_drain");
      end

      // overfill: writes past the last memory word are dropped
      do_reset();
      rand_prog(2050);
      load_prog();
      push_model();
      start();
      drain(2048, "full_mem_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
